apb_haptic_pwm: RTL
===================

Name: apb_haptic_pwm

Overview:
- APB3 slave on CoreAPB3 slot 2, a sibling of the distance sensor and LED slaves.
- Consumes MSS master transactions and drives the vibration-motor PWM pin, so firmware can turn measured distance into haptic feedback.
- Provides glitch-free shadowed duty/period registers and a hardware burst sequencer: ON n periods, OFF m periods, repeated N times.

Parameters:
- PWM_W, 16, width of the period counter, duty and period registers.
- DEFAULT_PERIOD, 1000, PERIOD reset value in PCLK cycles.
- BURST_W, 8, width of the burst count and remaining counter.

Ports:
- PCLK  input  1  system clock (FAB_CLK).
- PRESERN  input  1  synchronous reset, active-high.
- PSEL  input  1  slot select.
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  1 = write.
- PADDR  input  32  byte address; only [4:2] decoded.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data.
- PREADY  output  1  always 1.
- PSLVERR  output  1  error on undefined offset.
- motor_pwm  output  1  registered PWM drive to the motor.

Behaviour:
- Clock and reset: one clock, PCLK. PRESERN is synchronous and active-high; it clears all state on the PCLK edge where it is high.
- Reset values: motor_pwm=0, PRDATA=0, PSLVERR=0, CTRL=0, DUTY=0, PERIOD=DEFAULT_PERIOD, ON_OFF=0, BURST=0, state=IDLE, pwm counter=0.
- APB protocol:
  - Zero wait states.
  - A write commits on the PCLK edge with PSEL&PENABLE&PWRITE.
  - PRDATA is combinational from the decoded offset; unused bits read 0.
  - PSLVERR = PSEL&PENABLE&(offset>0x14). An errored write changes nothing.
- Register map:
  - 0x00 CTRL: [0] enable. Other bits read 0.
  - 0x04 DUTY: [PWM_W-1:0].
  - 0x08 PERIOD: [PWM_W-1:0].
  - 0x0C ON_OFF: [15:0] on_ticks, [31:16] off_ticks, both in PWM periods. A value of 0 is treated as 1.
  - 0x10 BURST: [BURST_W-1:0]. Writing it starts a sequence. 0 = continuous ON.
  - 0x14 STATUS (read-only): [0] busy, [15:8] bursts remaining.
- Shadowing:
  - DUTY and PERIOD writes go to staging registers.
  - Staging values are copied to the active registers only when the counter wraps (cnt==active_period-1), or when state is IDLE.
  - Result: no truncated or runt pulse.
- PWM counter:
  - Counts 0..active_period-1, then wraps to 0; counts only while state != IDLE.
  - active_period==0: counter held at 0, output 0.
- Output: motor_pwm <= (state==ON) && (cnt < duty_eff), with 1 cycle latency.
  - duty_eff ≥ period gives constant high.
  - duty_eff = 0 gives constant low.
- Sequencer states:
  - IDLE: entered on reset or when enable=0. Writing BURST while enable=1 loads remaining=N (or continuous if N=0), sets cnt=0 and tick=0, and goes to ON on the next edge.
  - ON: tick increments on each counter wrap.
    - When tick reaches on_ticks and continuous: stay in ON, tick=0.
    - Otherwise go to OFF, tick=0.
  - OFF: output 0; tick increments on each wrap. When tick reaches off_ticks:
    - remaining decrements.
    - If the result is 0, go to IDLE.
    - Otherwise go to ON.
- Busy: busy = (state!=IDLE).
- Boundary and simultaneous events:
  - Clearing enable in any state: IDLE on the next edge; motor_pwm low one cycle later.
  - BURST write while busy: restarts immediately, with counters reset to 0 and the new N loaded.
  - BURST write with enable=0: value stored, no start.
  - BURST write and CTRL write in the same cycle cannot happen on APB.
  - Reset asserted mid-burst overrides every other event in that cycle.
  - ON_OFF changes take effect at the next tick comparison.

Optional Feature:
- Macro: HAPTIC_RAMP_EN.
- Defined: on each entry to ON, duty_eff starts at 0 and increments by 1 per PWM period until it equals the active duty. If duty is lowered, duty_eff tracks down immediately. The ramp register is cleared in IDLE/OFF.
- Undefined: duty_eff = active duty; no ramp logic is synthesized.

Test Plan:
- Reset → PRDATA at 0x08 reads 1000; STATUS=0; motor_pwm=0; PSLVERR=0.
- PERIOD=10, DUTY=3, ON_OFF=0, enable=1, BURST=0 → motor_pwm high 3 of every 10 cycles continuously; busy=1.
- PERIOD=10, DUTY=5, ON_OFF={off=2,on=3}, BURST=2 → 3 periods of pulses, then 20 low cycles, then repeat once more → IDLE. Total 100 cycles; busy falls; STATUS[15:8]=0.
- DUTY written 3→7 mid-period at cnt=4 → current period keeps 3-high; the next period is 7-high; no runt pulse.
- Read 0x18 → PSLVERR=1, PRDATA=0, no state change. Clear enable mid-ON → motor_pwm=0 within 2 cycles; busy=0.
- HAPTIC_RAMP_EN defined, PERIOD=8, DUTY=3 → successive periods high for 0, 1, 2, 3, 3, ... cycles.

Source files
------------

// File: rtl/apb_haptic_pwm.sv
// APB3 slave driving a vibration-motor PWM with shadowed duty/period and an ON/OFF burst sequencer.
// Build option: define HAPTIC_RAMP_EN to ramp the effective duty up from 0 on every ON entry.
module apb_haptic_pwm #(
  parameter int PWM_W          = 16,
  parameter int DEFAULT_PERIOD = 1000,
  parameter int BURST_W        = 8
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        motor_pwm
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam logic [PWM_W-1:0]   CNT_ZERO = {PWM_W{1'b0}};
  localparam logic [BURST_W-1:0] REM_ZERO = {BURST_W{1'b0}};

  logic [2:0]         offset_s;
  logic               access_s;
  logic               wr_s;
  logic               wr_ctrl_s;
  logic               wr_duty_s;
  logic               wr_period_s;
  logic               wr_onoff_s;
  logic               wr_burst_s;
  logic               en_next_s;
  logic               busy_s;
  logic               wrap_s;
  logic               load_s;
  logic               unused_s;

  logic               ctrl_en_r;
  logic [PWM_W-1:0]   duty_stage_r;
  logic [PWM_W-1:0]   period_stage_r;
  logic [PWM_W-1:0]   duty_act_r;
  logic [PWM_W-1:0]   period_act_r;
  logic [PWM_W-1:0]   duty_eff_s;
  logic [15:0]        on_ticks_r;
  logic [15:0]        off_ticks_r;
  logic [15:0]        on_eff_s;
  logic [15:0]        off_eff_s;
  logic [BURST_W-1:0] burst_r;
  logic [31:0]        rem_ext_s;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [PWM_W-1:0]   cnt_r;
  logic [PWM_W-1:0]   cnt_nxt_s;
  logic [PWM_W-1:0]   cnt_adv_s;
  logic [15:0]        tick_r;
  logic [15:0]        tick_nxt_s;
  logic [16:0]        tick_inc_s;
  logic [BURST_W-1:0] remaining_r;
  logic [BURST_W-1:0] rem_nxt_s;
  logic               cont_r;
  logic               cont_nxt_s;
  logic               motor_pwm_r;

  assign offset_s    = PADDR[4:2];
  assign access_s    = PSEL & PENABLE;
  assign PSLVERR     = access_s & (offset_s > 3'd5);
  assign PREADY      = 1'b1;
  assign wr_s        = access_s & PWRITE & (offset_s <= 3'd5);
  assign wr_ctrl_s   = wr_s & (offset_s == 3'd0);
  assign wr_duty_s   = wr_s & (offset_s == 3'd1);
  assign wr_period_s = wr_s & (offset_s == 3'd2);
  assign wr_onoff_s  = wr_s & (offset_s == 3'd3);
  assign wr_burst_s  = wr_s & (offset_s == 3'd4);
  assign en_next_s   = wr_ctrl_s ? PWDATA[0] : ctrl_en_r;

  assign busy_s     = (state_r != ST_IDLE);
  assign rem_ext_s  = 32'(remaining_r);
  assign unused_s   = ^{PADDR[31:5], PADDR[1:0], rem_ext_s[31:8]};
  assign on_eff_s   = (on_ticks_r == 16'd0) ? 16'd1 : on_ticks_r;
  assign off_eff_s  = (off_ticks_r == 16'd0) ? 16'd1 : off_ticks_r;
  assign tick_inc_s = {1'b0, tick_r} + 17'd1;

  // A zero period never wraps, so the shadow is allowed through while it is held there
  assign wrap_s    = (period_act_r != CNT_ZERO) && (cnt_r == period_act_r - PWM_W'(1));
  assign load_s    = (state_r == ST_IDLE) || wrap_s || (period_act_r == CNT_ZERO);
  assign cnt_adv_s = (wrap_s || (period_act_r == CNT_ZERO)) ? CNT_ZERO : cnt_r + PWM_W'(1);

`ifdef HAPTIC_RAMP_EN
  logic [PWM_W-1:0] ramp_r;

  assign duty_eff_s = (ramp_r < duty_act_r) ? ramp_r : duty_act_r;

  // Duty ramp: cleared outside ON, steps once per period towards the active duty
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      ramp_r <= CNT_ZERO;
    end else if ((state_r != ST_ON) || wr_burst_s) begin
      ramp_r <= CNT_ZERO;
    end else if (ramp_r > duty_act_r) begin
      ramp_r <= duty_act_r;
    end else if (wrap_s && (ramp_r < duty_act_r)) begin
      ramp_r <= ramp_r + PWM_W'(1);
    end else begin
      ramp_r <= ramp_r;
    end
  end
`else
  assign duty_eff_s = duty_act_r;
`endif

  // APB register writes plus the staging-to-active transfer at period boundaries
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      ctrl_en_r      <= 1'b0;
      duty_stage_r   <= CNT_ZERO;
      period_stage_r <= PWM_W'(DEFAULT_PERIOD);
      duty_act_r     <= CNT_ZERO;
      period_act_r   <= PWM_W'(DEFAULT_PERIOD);
      on_ticks_r     <= 16'd0;
      off_ticks_r    <= 16'd0;
      burst_r        <= REM_ZERO;
    end else begin
      if (wr_ctrl_s)   ctrl_en_r      <= PWDATA[0];
      if (wr_duty_s)   duty_stage_r   <= PWDATA[PWM_W-1:0];
      if (wr_period_s) period_stage_r <= PWDATA[PWM_W-1:0];
      if (wr_onoff_s) begin
        on_ticks_r  <= PWDATA[15:0];
        off_ticks_r <= PWDATA[31:16];
      end
      if (wr_burst_s)  burst_r        <= PWDATA[BURST_W-1:0];
      if (load_s) begin
        duty_act_r   <= duty_stage_r;
        period_act_r <= period_stage_r;
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      tick_r      <= 16'd0;
      remaining_r <= REM_ZERO;
      cont_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      tick_r      <= tick_nxt_s;
      remaining_r <= rem_nxt_s;
      cont_r      <= cont_nxt_s;
    end
  end

  // Sequencer next state: disable wins, then a BURST write restarts, then normal ticking
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    tick_nxt_s  = tick_r;
    rem_nxt_s   = remaining_r;
    cont_nxt_s  = cont_r;
    if (!en_next_s) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = CNT_ZERO;
      tick_nxt_s  = 16'd0;
      rem_nxt_s   = REM_ZERO;
    end else if (wr_burst_s) begin
      state_nxt_s = ST_ON;
      cnt_nxt_s   = CNT_ZERO;
      tick_nxt_s  = 16'd0;
      rem_nxt_s   = PWDATA[BURST_W-1:0];
      cont_nxt_s  = (PWDATA[BURST_W-1:0] == REM_ZERO);
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_nxt_s  = CNT_ZERO;
          tick_nxt_s = 16'd0;
        end
        ST_ON: begin
          cnt_nxt_s = cnt_adv_s;
          if (wrap_s) begin
            if (tick_inc_s >= {1'b0, on_eff_s}) begin
              tick_nxt_s  = 16'd0;
              state_nxt_s = cont_r ? ST_ON : ST_OFF;
            end else begin
              tick_nxt_s = tick_inc_s[15:0];
            end
          end else begin
            tick_nxt_s = tick_r;
          end
        end
        ST_OFF: begin
          cnt_nxt_s = cnt_adv_s;
          if (wrap_s) begin
            if (tick_inc_s >= {1'b0, off_eff_s}) begin
              tick_nxt_s = 16'd0;
              if (remaining_r <= BURST_W'(1)) begin
                rem_nxt_s   = REM_ZERO;
                state_nxt_s = ST_IDLE;
              end else begin
                rem_nxt_s   = remaining_r - BURST_W'(1);
                state_nxt_s = ST_ON;
              end
            end else begin
              tick_nxt_s = tick_inc_s[15:0];
            end
          end else begin
            tick_nxt_s = tick_r;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
          tick_nxt_s  = 16'd0;
        end
      endcase
    end
  end

  // Registered motor drive; low everywhere except the high part of an ON period
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      motor_pwm_r <= 1'b0;
    end else begin
      motor_pwm_r <= (state_r == ST_ON) && (cnt_r < duty_eff_s);
    end
  end

  assign motor_pwm = motor_pwm_r;

  // Read mux; DUTY/PERIOD read back the staged values firmware last wrote
  always_comb begin
    PRDATA = 32'd0;
    case (offset_s)
      3'd0:    PRDATA = {31'd0, ctrl_en_r};
      3'd1:    PRDATA = 32'(duty_stage_r);
      3'd2:    PRDATA = 32'(period_stage_r);
      3'd3:    PRDATA = {off_ticks_r, on_ticks_r};
      3'd4:    PRDATA = 32'(burst_r);
      3'd5:    PRDATA = {16'd0, rem_ext_s[7:0], 7'd0, busy_s};
      default: PRDATA = 32'd0;
    endcase
  end

endmodule
